// File: rtl/inst_mem_pkg.sv
// Shared types, constants and address helpers for the wait-state instruction memory.
package inst_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int unsigned CNT_W            = 3;
  localparam logic [31:0] DEFAULT_INST_VAL = 32'h0000_0000;

  // Word index wraps modulo the depth; callers truncate to the array address width.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth);
    return (addr >> 2) & (depth - 1);
  endfunction

  function automatic logic addr_fault(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Word array with one synchronous write port and one enabled synchronous read port.
module inst_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Separate process so a same-edge read samples the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_ws.sv
// Instruction memory behind a valid/ready fetch handshake with configurable wait states and flush.
module inst_mem_ws
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned WAIT_STATES  = 2,
  parameter logic [31:0] DEFAULT_INST = DEFAULT_INST_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_fault,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             fault_q;
  logic             accept;
  logic             enter_resp;
  logic [31:0]      rd_addr;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    ld_idx;
  logic [31:0]      rd_data;

  // With zero wait states the read must be issued from the live request address.
  assign rd_addr = accept ? req_addr : addr_q;
  assign rd_idx  = AW'(word_index(rd_addr, DEPTH_WORDS));
  assign ld_idx  = AW'(word_index(load_addr, DEPTH_WORDS));

  inst_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (load_en),
    .waddr_i (ld_idx),
    .wdata_i (load_data),
    .re_i    (enter_resp),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    req_ready  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !flush;
        accept    = req_valid && !flush;
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP: begin
        req_ready = resp_ready && !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (resp_ready) begin
          if (req_valid) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      addr_d = req_addr;
      cnt_d  = CNT_W'(WAIT_STATES);
      if (WAIT_STATES == 0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (enter_resp) begin
        fault_q <= addr_fault(rd_addr, DEPTH_WORDS);
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_fault = fault_q;
  assign resp_inst  = fault_q ? DEFAULT_INST : rd_data;

endmodule

// File: doc/inst_mem_ws.md
# inst_mem_ws

Parametrised, wait-state instruction memory for the ARM pipeline fetch stage. It replaces a purely combinational instruction lookup with a byte-addressed, word-organised array behind a valid/ready fetch handshake. It has a configurable number of wait states, alignment/range fault reporting and a branch flush. A word-wide load port lets the bench or boot logic program the array at run time.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 2: extra cycles between request accept and response; range 0–7.
- DEFAULT_INST, 32'h0000_0000: instruction returned on any fault.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- resp_valid  out  1  response holds a fetched instruction.
- resp_ready  in  1  fetch stage consumes the response.
- resp_inst  out  32  fetched instruction word.
- resp_fault  out  1  request was misaligned or out of range.
- flush  in  1  branch taken; cancel any outstanding fetch.
- load_en  in  1  write one word through the load port.
- load_addr  in  32  byte address of the load; bits [1:0] are ignored.
- load_data  in  32  word to write.

## Operation
- FSM states: IDLE, WAIT, RESP. A counter (3 bits) tracks the remaining wait states.
- IDLE:
  - req_ready = !flush.
  - On req_valid && req_ready, capture req_addr and load the counter with WAIT_STATES.
  - If WAIT_STATES == 0, go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Entering RESP (the edge leaving IDLE or WAIT), register the result:
  - If captured addr[1:0] != 0, or addr>>2 ≥ DEPTH_WORDS: resp_fault = 1 and resp_inst = DEFAULT_INST.
  - Otherwise: resp_fault = 0 and resp_inst = mem[addr>>2].
- RESP:
  - resp_valid = 1. resp_inst and resp_fault are held stable until the handshake.
  - req_ready = resp_ready && !flush.
  - On resp_ready, if req_valid is also high, accept the new request in the same cycle (back-to-back) and go to WAIT or RESP per WAIT_STATES. Otherwise go to IDLE.
- flush:
  - In WAIT or RESP, go to IDLE on the next edge, with no response delivered. resp_valid drops to 0 that edge.
  - flush has priority over resp_ready and over a simultaneous new request, which is not accepted.
- Load port:
  - When load_en is high, mem[load_addr>>2 mod DEPTH_WORDS] = load_data on the edge.
  - Loads are independent of the FSM.
  - A read sampled on the same edge as a write to the same word returns the old value (read-before-write).
- Memory contents are not affected by rst and are X until loaded.

## Timing
- Reset values: state IDLE, counter 0, resp_valid 0, resp_inst 0, resp_fault 0. req_ready reads 1 after reset release (IDLE, no flush).
- Latency: response valid (WAIT_STATES + 1) cycles after the accept edge.
- Throughput:
  - WAIT_STATES = 0: one instruction per cycle, with back-to-back accept in RESP.
  - Otherwise: one instruction per (WAIT_STATES + 1) cycles.
- Reset mid-operation: rst asserted in WAIT or RESP forces IDLE immediately (asynchronously). resp_valid clears at once, and the outstanding fetch is lost.
- A response stalled by resp_ready = 0 is held indefinitely. No new request is accepted during the stall.

## Structure
- Shared package inst_mem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Wait-counter width constant (3).
  - Default value for DEFAULT_INST.
  - Function word_index(addr, DEPTH_WORDS).
  - Function addr_fault(addr, DEPTH_WORDS).
- Sub-module inst_mem_array: DEPTH_WORDS × 32 array with one synchronous write port and one synchronous read port (read enable, read-before-write).
- Top level contains the FSM, the wait counter, the fault check and the response registers.

## Test plan
- WAIT_STATES = 2, load mem[1] = 32'hE492_3002, then request addr 4 → resp_valid rises 3 cycles after accept with resp_inst = 32'hE492_3002 and resp_fault = 0.
- Request addr 6, then addr 4096 with DEPTH_WORDS = 1024 → resp_fault = 1 and resp_inst = 32'h0000_0000 for both.
- WAIT_STATES = 0 with req_valid and resp_ready held high over addrs 0, 4, 8 → one response per cycle, in order, and req_ready stays 1.
- Assert flush one cycle after accept (WAIT_STATES = 2) → no resp_valid for that request. The next request, at addr 8, returns mem[2].
- Hold resp_ready = 0 for 5 cycles in RESP → resp_inst and resp_fault are stable and req_ready = 0. Release → handshake completes and the FSM returns to IDLE.
- Pulse rst asynchronously while in WAIT → resp_valid = 0 immediately and the FSM is in IDLE. Then load_en writes 32'h1234_5678 to addr 0 on the same edge as a read of addr 0 is sampled → the read returns the old word and the next read returns 32'h1234_5678.
